dmem_responder: RTL and testbench

//  Data-memory responder: the memory-side end of the datapath's load/store port.

---
 rtl/dmem_responder_pkg.sv | 38 +++
 rtl/dmem_responder_if.sv | 26 ++
 rtl/dmem_responder_load_extend.sv | 41 ++++
 rtl/dmem_responder.sv | 201 ++++++++++++++++++++
 tb/tb_dmem_responder.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: access sizes, FSM states,
// default base address and byte-lane helpers.
package riscv_mem_pkg;

    localparam logic [1:0]  SIZE_B    = 2'b00;
    localparam logic [1:0]  SIZE_H    = 2'b01;
    localparam logic [1:0]  SIZE_W    = 2'b10;
    localparam logic [31:0] DMEM_BASE = 32'h1001_0000;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } dmem_state_t;

    function automatic logic size_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic bad;
        case (size)
            SIZE_B:  bad = 1'b0;
            SIZE_H:  bad = addr_lo[0];
            SIZE_W:  bad = (addr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] addr_lo);
        logic [3:0] mask;
        case (size)
            SIZE_B:  mask = 4'b0001 << addr_lo;
            SIZE_H:  mask = 4'b0011 << addr_lo;
            SIZE_W:  mask = 4'b1111;
            default: mask = 4'b0000;
        endcase
        return mask;
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store port between the core (master) and the data-memory responder (slave).
interface dmem_responder_if;

    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );

endinterface

// File: rtl/dmem_responder_load_extend.sv
// Picks the addressed byte/half/word out of a raw memory word and sign- or
// zero-extends it to 32 bits. Reserved size yields zero.
module load_extend
    import riscv_mem_pkg::*;
(
    input  logic [1:0]  i_addr_lo,
    input  logic [1:0]  i_size,
    input  logic        i_unsigned,
    input  logic [31:0] i_word,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // lane selection followed by extension
    always_comb begin
        w_byte = 8'h00;
        w_half = 16'h0000;
        o_data = 32'h0000_0000;
        case (i_addr_lo)
            2'b00:   w_byte = i_word[7:0];
            2'b01:   w_byte = i_word[15:8];
            2'b10:   w_byte = i_word[23:16];
            2'b11:   w_byte = i_word[31:24];
            default: w_byte = 8'h00;
        endcase
        if (i_addr_lo[1]) begin
            w_half = i_word[31:16];
        end else begin
            w_half = i_word[15:0];
        end
        case (i_size)
            SIZE_B:  o_data = i_unsigned ? {24'h00_0000, w_byte} : {{24{w_byte[7]}}, w_byte};
            SIZE_H:  o_data = i_unsigned ? {16'h0000, w_half} : {{16{w_half[15]}}, w_half};
            SIZE_W:  o_data = i_word;
            default: o_data = 32'h0000_0000;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Memory-side end of the core's load/store port: one request at a time,
// fixed wait-state latency, byte/half/word access with error reporting.
module dmem_responder
    import riscv_mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DMEM_BASE,
    parameter int unsigned DEPTH_WORDS = 1024,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic             clk,
    input  logic             rst,
    dmem_responder_if.slave  bus
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  WS    = 4'(WAIT_STATES);
    localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + (33'(DEPTH_WORDS) * 33'd4);

    dmem_state_t r_state;
    dmem_state_t w_state_nxt;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [1:0]  r_size;
    logic        r_unsigned;
    logic        r_resp_valid;
    logic [31:0] r_rdata;
    logic        r_err;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic             w_req_ready;
    logic             w_accept;
    logic             w_access;
    logic             w_a_we;
    logic [31:0]      w_a_addr;
    logic [31:0]      w_a_wdata;
    logic [1:0]       w_a_size;
    logic             w_a_unsigned;
    logic [31:0]      w_off;
    logic [IDX_W-1:0] w_idx;
    logic             w_err;
    logic [3:0]       w_mask;
    logic [31:0]      w_wlanes;
    logic [31:0]      w_word;
    logic [31:0]      w_ext;

    assign w_accept = bus.req_valid & w_req_ready;

    // state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt = (WS == 4'd0) ? RESP : WAIT;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            WAIT: begin
                if (r_cnt == 4'd1) begin
                    w_state_nxt = RESP;
                end else begin
                    w_state_nxt = WAIT;
                end
            end
            RESP: begin
                if (bus.resp_ready) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = RESP;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // FSM control outputs; with zero wait states the access happens in the accept cycle
    always_comb begin
        w_req_ready = 1'b0;
        w_access    = 1'b0;
        case (r_state)
            IDLE: begin
                w_req_ready = ~rst;
                w_access    = bus.req_valid & ~rst & (WS == 4'd0);
            end
            WAIT:    w_access = (r_cnt == 4'd1);
            RESP:    w_access = 1'b0;
            default: w_access = 1'b0;
        endcase
    end

    // access operands come straight from the bus only on a zero-wait accept
    always_comb begin
        if (r_state == IDLE) begin
            w_a_we       = bus.req_we;
            w_a_addr     = bus.req_addr;
            w_a_wdata    = bus.req_wdata;
            w_a_size     = bus.req_size;
            w_a_unsigned = bus.req_unsigned;
        end else begin
            w_a_we       = r_we;
            w_a_addr     = r_addr;
            w_a_wdata    = r_wdata;
            w_a_size     = r_size;
            w_a_unsigned = r_unsigned;
        end
    end

    assign w_off  = w_a_addr - BASE_ADDR;
    assign w_idx  = IDX_W'(w_off >> 2);
    assign w_err  = ({1'b0, w_a_addr} < {1'b0, BASE_ADDR}) | ({1'b0, w_a_addr} >= LIMIT)
                  | size_misaligned(w_a_size, w_a_addr[1:0]);
    assign w_mask = lane_mask(w_a_size, w_a_addr[1:0]);
    assign w_word = r_mem[w_idx];

    // replicate right-justified store data across every lane it may land in
    always_comb begin
        case (w_a_size)
            SIZE_B:  w_wlanes = {4{w_a_wdata[7:0]}};
            SIZE_H:  w_wlanes = {2{w_a_wdata[15:0]}};
            default: w_wlanes = w_a_wdata;
        endcase
    end

    load_extend u_load_extend (
        .i_addr_lo  (w_a_addr[1:0]),
        .i_size     (w_a_size),
        .i_unsigned (w_a_unsigned),
        .i_word     (w_word),
        .o_data     (w_ext)
    );

    // request capture and wait-state counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= 4'd0;
            r_we       <= 1'b0;
            r_addr     <= 32'h0000_0000;
            r_wdata    <= 32'h0000_0000;
            r_size     <= 2'b00;
            r_unsigned <= 1'b0;
        end else if (w_accept) begin
            r_cnt      <= WS;
            r_we       <= bus.req_we;
            r_addr     <= bus.req_addr;
            r_wdata    <= bus.req_wdata;
            r_size     <= bus.req_size;
            r_unsigned <= bus.req_unsigned;
        end else if (r_state == WAIT) begin
            r_cnt <= r_cnt - 4'd1;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // response registers, loaded in the access cycle and held through RESP
    always_ff @(posedge clk) begin
        if (rst) begin
            r_resp_valid <= 1'b0;
            r_rdata      <= 32'h0000_0000;
            r_err        <= 1'b0;
        end else begin
            r_resp_valid <= (w_state_nxt == RESP);
            if (w_access) begin
                r_err   <= w_err;
                r_rdata <= (w_err | w_a_we) ? 32'h0000_0000 : w_ext;
            end else begin
                r_err   <= r_err;
                r_rdata <= r_rdata;
            end
        end
    end

    // storage write; reset in the commit cycle suppresses it
    always_ff @(posedge clk) begin
        if (!rst && w_access && w_a_we && !w_err) begin
            for (int i = 0; i < 4; i++) begin
                if (w_mask[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_wlanes[8*i +: 8];
                end
            end
        end
    end

    assign bus.req_ready  = w_req_ready;
    assign bus.resp_valid = r_resp_valid;
    assign bus.resp_rdata = r_rdata;
    assign bus.resp_err   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: a 2-wait-state and a 0-wait-state instance share
// stimulus; directed vector table, reset-abort sequence, then random traffic vs a byte model.
module tb_dmem_responder;
    import riscv_mem_pkg::*;

    localparam logic [31:0] BASE = 32'h1001_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic        resp_ready;

    int checks = 0;
    int errors = 0;
    logic [7:0] m [0:4095];

    always #5 clk = ~clk;

    dmem_responder_if b2 ();
    dmem_responder_if b0 ();

    assign b2.req_valid    = req_valid;
    assign b2.req_we       = req_we;
    assign b2.req_addr     = req_addr;
    assign b2.req_wdata    = req_wdata;
    assign b2.req_size     = req_size;
    assign b2.req_unsigned = req_unsigned;
    assign b2.resp_ready   = resp_ready;
    assign b0.req_valid    = req_valid;
    assign b0.req_we       = req_we;
    assign b0.req_addr     = req_addr;
    assign b0.req_wdata    = req_wdata;
    assign b0.req_size     = req_size;
    assign b0.req_unsigned = req_unsigned;
    assign b0.resp_ready   = resp_ready;

    dmem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(1024), .WAIT_STATES(2)) dut (
        .clk (clk), .rst (rst), .bus (b2.slave));
    dmem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(1024), .WAIT_STATES(0)) dut0 (
        .clk (clk), .rst (rst), .bus (b0.slave));

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        uns;
        int          hold;
        logic [31:0] exp_d;
        logic        exp_e;
    } vec_t;

    vec_t tbl [17];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic m_err(input logic [31:0] a, input logic [1:0] sz);
        if (sz == 2'b11) return 1'b1;
        if (sz == 2'b01 && a[0]) return 1'b1;
        if (sz == 2'b10 && a[1:0] != 2'b00) return 1'b1;
        if (a < BASE || a >= BASE + 32'd4096) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] m_load(input logic [31:0] a, input logic [1:0] sz, input logic un);
        int off;
        int n;
        logic [31:0] v;
        off = int'(a - BASE);
        n   = 1 << sz;
        v   = 32'h0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = m[off + i];
        if (!un && n < 4 && v[8*n-1]) begin
            for (int i = 8*n; i < 32; i++) v[i] = 1'b1;
        end
        return v;
    endfunction

    task automatic m_store(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] sz);
        int off;
        off = int'(a - BASE);
        for (int i = 0; i < (1 << sz); i++) m[off + i] = wd[8*i +: 8];
    endtask

    // one full transaction on both instances; ed2/ee2 for the 2-wait DUT, ed0/ee0 for the 0-wait DUT
    task automatic txn(input string nm, input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [1:0] sz, input logic un, input int hold,
                       input logic [31:0] ed2, input logic ee2, input logic [31:0] ed0, input logic ee0);
        int n;
        int l2;
        int l0;
        logic [31:0] h2;
        logic [31:0] h0;
        @(negedge clk);
        req_we = we; req_addr = a; req_wdata = wd; req_size = sz; req_unsigned = un;
        req_valid = 1'b1; resp_ready = 1'b0;
        n = 0;
        while (!(b2.req_ready && b0.req_ready) && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk({nm, " accept"}, 32'(n < 10), 32'd1);
        @(negedge clk);
        req_valid = 1'b0; req_we = ~we; req_addr = $urandom; req_wdata = $urandom;
        req_size = 2'($urandom_range(0, 3)); req_unsigned = ~un;
        l2 = 0;
        l0 = 0;
        for (int c = 1; c <= 10; c++) begin
            if (l0 == 0 && b0.resp_valid) l0 = c;
            if (l2 == 0 && b2.resp_valid) l2 = c;
            if (l0 != 0 && l2 != 0) break;
            @(negedge clk);
        end
        chk({nm, " latency ws2"}, 32'(l2), 32'd3);
        chk({nm, " latency ws0"}, 32'(l0), 32'd1);
        h2 = b2.resp_rdata;
        h0 = b0.resp_rdata;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            chk({nm, " bp valid"}, {30'd0, b2.resp_valid, b0.resp_valid}, 32'd3);
            chk({nm, " bp req_ready"}, {30'd0, b2.req_ready, b0.req_ready}, 32'd0);
            chk({nm, " bp rdata ws2"}, b2.resp_rdata, h2);
            chk({nm, " bp rdata ws0"}, b0.resp_rdata, h0);
        end
        resp_ready = 1'b1;
        chk({nm, " rdata ws2"}, b2.resp_rdata, ed2);
        chk({nm, " err ws2"}, {31'd0, b2.resp_err}, {31'd0, ee2});
        chk({nm, " rdata ws0"}, b0.resp_rdata, ed0);
        chk({nm, " err ws0"}, {31'd0, b0.resp_err}, {31'd0, ee0});
        @(negedge clk);
        resp_ready = 1'b0;
        chk({nm, " post valid"}, {30'd0, b2.resp_valid, b0.resp_valid}, 32'd0);
        chk({nm, " post req_ready"}, {30'd0, b2.req_ready, b0.req_ready}, 32'd3);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic        we;
        logic        un;
        logic        e;
        logic [1:0]  sz;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] d;
        int          pick;

        tbl[0]  = '{1'b1, 32'h1001_0004, 32'hDEAD_BEEF, SIZE_W, 1'b0, 0, 32'h0000_0000, 1'b0};
        tbl[1]  = '{1'b0, 32'h1001_0004, 32'h0000_0000, SIZE_W, 1'b0, 5, 32'hDEAD_BEEF, 1'b0};
        tbl[2]  = '{1'b1, 32'h1001_0005, 32'h0000_0080, SIZE_B, 1'b0, 0, 32'h0000_0000, 1'b0};
        tbl[3]  = '{1'b0, 32'h1001_0005, 32'h0000_0000, SIZE_B, 1'b0, 1, 32'hFFFF_FF80, 1'b0};
        tbl[4]  = '{1'b0, 32'h1001_0005, 32'h0000_0000, SIZE_B, 1'b1, 0, 32'h0000_0080, 1'b0};
        tbl[5]  = '{1'b0, 32'h1001_0004, 32'h0000_0000, SIZE_W, 1'b1, 0, 32'hDEAD_80EF, 1'b0};
        tbl[6]  = '{1'b1, 32'h1001_0000, 32'h1234_5678, SIZE_W, 1'b0, 0, 32'h0000_0000, 1'b0};
        tbl[7]  = '{1'b0, 32'h1001_0003, 32'h0000_0000, SIZE_H, 1'b0, 0, 32'h0000_0000, 1'b1};
        tbl[8]  = '{1'b1, 32'h1001_0002, 32'hAAAA_AAAA, SIZE_W, 1'b0, 0, 32'h0000_0000, 1'b1};
        tbl[9]  = '{1'b0, 32'h1001_0000, 32'h0000_0000, SIZE_W, 1'b0, 0, 32'h1234_5678, 1'b0};
        tbl[10] = '{1'b0, 32'h1000_FFFC, 32'h0000_0000, SIZE_W, 1'b0, 0, 32'h0000_0000, 1'b1};
        tbl[11] = '{1'b0, 32'h1001_1000, 32'h0000_0000, SIZE_W, 1'b0, 0, 32'h0000_0000, 1'b1};
        tbl[12] = '{1'b1, 32'h1001_0FFC, 32'hCAFE_F00D, SIZE_W, 1'b0, 0, 32'h0000_0000, 1'b0};
        tbl[13] = '{1'b0, 32'h1001_0FFC, 32'h0000_0000, SIZE_W, 1'b0, 0, 32'hCAFE_F00D, 1'b0};
        tbl[14] = '{1'b0, 32'h1001_0006, 32'h0000_0000, SIZE_H, 1'b0, 2, 32'hFFFF_DEAD, 1'b0};
        tbl[15] = '{1'b0, 32'h1001_0006, 32'h0000_0000, SIZE_H, 1'b1, 0, 32'h0000_DEAD, 1'b0};
        tbl[16] = '{1'b0, 32'h1001_0004, 32'h0000_0000, 2'b11,  1'b0, 0, 32'h0000_0000, 1'b1};

        rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
        req_size = 2'b00; req_unsigned = 1'b0; resp_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset req_ready", {30'd0, b2.req_ready, b0.req_ready}, 32'd0);
        chk("reset resp_valid", {30'd0, b2.resp_valid, b0.resp_valid}, 32'd0);
        chk("reset rdata", b2.resp_rdata | b0.resp_rdata, 32'd0);
        chk("reset err", {30'd0, b2.resp_err, b0.resp_err}, 32'd0);
        rst = 1'b0;
        #1;
        chk("release req_ready", {30'd0, b2.req_ready, b0.req_ready}, 32'd3);

        // known contents for the first 16 words so random loads are defined
        for (int w = 0; w < 16; w++) begin
            wd = $urandom;
            txn($sformatf("init%0d", w), 1'b1, BASE + 32'(4 * w), wd, SIZE_W, 1'b0, 0,
                32'h0, 1'b0, 32'h0, 1'b0);
            m_store(BASE + 32'(4 * w), wd, SIZE_W);
        end

        for (int i = 0; i < 17; i++) begin
            txn($sformatf("vec%0d", i), tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].size,
                tbl[i].uns, tbl[i].hold, tbl[i].exp_d, tbl[i].exp_e, tbl[i].exp_d, tbl[i].exp_e);
            if (tbl[i].we && !tbl[i].exp_e) m_store(tbl[i].addr, tbl[i].wdata, tbl[i].size);
        end

        // reset one cycle after a store accept: 2-wait DUT never commits, 0-wait DUT already has
        txn("rst_pre", 1'b1, 32'h1001_0008, 32'h1111_1111, SIZE_W, 1'b0, 0, 32'h0, 1'b0, 32'h0, 1'b0);
        m_store(32'h1001_0008, 32'h1111_1111, SIZE_W);
        @(negedge clk);
        req_we = 1'b1; req_addr = 32'h1001_0008; req_wdata = 32'h2222_2222; req_size = SIZE_W;
        req_unsigned = 1'b0; req_valid = 1'b1; resp_ready = 1'b0;
        @(negedge clk);
        rst = 1'b1; req_valid = 1'b0;
        #1;
        chk("rst mid req_ready", {30'd0, b2.req_ready, b0.req_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("rst abort no resp", {30'd0, b2.resp_valid, b0.resp_valid}, 32'd0);
        end
        txn("rst_lw", 1'b0, 32'h1001_0008, 32'h0, SIZE_W, 1'b0, 0,
            32'h1111_1111, 1'b0, 32'h2222_2222, 1'b0);
        txn("rst_sync", 1'b1, 32'h1001_0008, 32'h3333_3333, SIZE_W, 1'b0, 0, 32'h0, 1'b0, 32'h0, 1'b0);
        m_store(32'h1001_0008, 32'h3333_3333, SIZE_W);

        for (int r = 0; r < 150; r++) begin
            we   = 1'($urandom_range(0, 1));
            un   = 1'($urandom_range(0, 1));
            sz   = ($urandom_range(0, 9) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            wd   = $urandom;
            pick = int'($urandom_range(0, 9));
            if (pick < 8) a = BASE + $urandom_range(0, 63);
            else if (pick == 8) a = BASE + 32'd4092 + $urandom_range(0, 3);
            else if ($urandom_range(0, 1) == 0) a = BASE - $urandom_range(1, 4);
            else a = BASE + 32'd4096 + $urandom_range(0, 3);
            e = m_err(a, sz);
            d = (e || we) ? 32'h0 : m_load(a, sz, un);
            txn($sformatf("rnd%0d", r), we, a, wd, sz, un, int'($urandom_range(0, 3)), d, e, d, e);
            if (we && !e) m_store(a, wd, sz);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
